// File: rtl/rtlola_pkg.sv
// Shared aggregation types and fold helpers for the RTLola window units.
// Values are carried sign-extended in AGG_W bits so one function serves every DATA_W up to AGG_W.
package rtlola_pkg;

    localparam int AGG_W = 128;

    typedef logic signed [AGG_W-1:0] agg_t;

    typedef enum logic [1:0] {
        AGG_SUM   = 2'd0,
        AGG_COUNT = 2'd1,
        AGG_MAX   = 2'd2
    } agg_mode_t;

    function automatic agg_t agg_identity(input agg_mode_t mode, input int width);
        if (mode == AGG_MAX) begin
            return -(agg_t'(1) <<< (width - 1));
        end
        return '0;
    endfunction

    // Sum and count both combine by addition; count saturation is the caller's job.
    function automatic agg_t agg_fold(input agg_mode_t mode, input agg_t acc, input agg_t x);
        if (mode == AGG_MAX) begin
            return (x > acc) ? x : acc;
        end
        return acc + x;
    endfunction

endpackage

// File: rtl/rtlola_window_reduce.sv
// Combinational reduction of all window buckets into one aggregate plus an empty flag.
module rtlola_window_reduce
    import rtlola_pkg::*;
#(
    parameter int        DATA_W      = 64,
    parameter int        NUM_BUCKETS = 2,
    parameter agg_mode_t MODE        = AGG_SUM
) (
    input  logic [NUM_BUCKETS*DATA_W-1:0] buckets_i,
    input  logic [NUM_BUCKETS-1:0]        occ_i,
    output logic signed [DATA_W-1:0]      agg_o,
    output logic                          empty_o
);

    logic signed [DATA_W-1:0] acc;

    // Unoccupied buckets hold the identity, so folding every bucket is safe.
    always_comb begin
        acc = DATA_W'(agg_identity(MODE, DATA_W));
        for (int i = 0; i < NUM_BUCKETS; i++) begin
            acc = DATA_W'(agg_fold(MODE, agg_t'(acc),
                                   agg_t'($signed(buckets_i[i*DATA_W +: DATA_W]))));
        end
        empty_o = ~|occ_i;
        agg_o   = empty_o ? '0 : acc;
    end

endmodule

// File: rtl/rtlola_sliding_window.sv
// Sliding-window aggregator: circular bucket buffer rotated on tick, registered window query.
module rtlola_sliding_window
    import rtlola_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int NUM_BUCKETS = 2,
    parameter int MODE        = 0,
    parameter int IDX_W       = $clog2(NUM_BUCKETS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic                          in_valid,
    input  logic                          tick,
    input  logic                          query,
    output logic signed [DATA_W-1:0]      out_data,
    output logic                          out_valid,
    output logic                          out_empty,
    output logic [IDX_W-1:0]              head_idx,
    output logic [NUM_BUCKETS*DATA_W-1:0] buckets
);

    localparam agg_mode_t                AMODE   = agg_mode_t'(MODE[1:0]);
    localparam logic signed [DATA_W-1:0] IDENT   = DATA_W'(agg_identity(AMODE, DATA_W));
    localparam logic signed [DATA_W-1:0] CNT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [IDX_W-1:0]         LAST    = IDX_W'(NUM_BUCKETS - 1);

    logic signed [DATA_W-1:0]      bkt_q [NUM_BUCKETS];
    logic signed [DATA_W-1:0]      bkt_d [NUM_BUCKETS];
    logic [NUM_BUCKETS-1:0]        occ_q, occ_d;
    logic [IDX_W-1:0]              head_q, head_d;
    logic signed [DATA_W-1:0]      out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          out_empty_q, out_empty_d;
    logic [NUM_BUCKETS*DATA_W-1:0] flat_d, flat_q;
    logic signed [DATA_W-1:0]      red_agg;
    logic                          red_empty;

    // Window update in the fixed order tick, then sample; the query sees the result.
    always_comb begin
        bkt_d  = bkt_q;
        occ_d  = occ_q;
        head_d = head_q;
        if (en) begin
            if (tick) begin
                head_d         = (head_q == LAST) ? '0 : head_q + IDX_W'(1);
                bkt_d[head_d]  = IDENT;
                occ_d[head_d]  = 1'b0;
            end
            if (in_valid) begin
                if (AMODE == AGG_COUNT) begin
                    if (bkt_d[head_d] != CNT_MAX) begin
                        bkt_d[head_d] = DATA_W'(agg_fold(AMODE, agg_t'(bkt_d[head_d]), agg_t'(1)));
                    end
                end else begin
                    bkt_d[head_d] = DATA_W'(agg_fold(AMODE, agg_t'(bkt_d[head_d]), agg_t'(in_data)));
                end
                occ_d[head_d] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BUCKETS; i++) begin
            flat_d[i*DATA_W +: DATA_W] = bkt_d[i];
            flat_q[i*DATA_W +: DATA_W] = bkt_q[i];
        end
    end

    rtlola_window_reduce #(
        .DATA_W      (DATA_W),
        .NUM_BUCKETS (NUM_BUCKETS),
        .MODE        (AMODE)
    ) u_reduce (
        .buckets_i (flat_d),
        .occ_i     (occ_d),
        .agg_o     (red_agg),
        .empty_o   (red_empty)
    );

    always_comb begin
        out_valid_d = en & query;
        out_data_d  = out_data_q;
        out_empty_d = out_empty_q;
        if (en && query) begin
            out_data_d  = red_agg;
            out_empty_d = red_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUCKETS; i++) begin
                bkt_q[i] <= IDENT;
            end
            occ_q       <= '0;
            head_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_empty_q <= 1'b0;
        end else begin
            bkt_q       <= bkt_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_empty_q <= out_empty_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_empty = out_empty_q;
    assign head_idx  = head_q;
    assign buckets   = flat_q;

endmodule

// File: tb/tb_rtlola_sliding_window.sv
// Bench: five differently configured windows share one stimulus stream and are checked against a sample-history model.
module tb_rtlola_sliding_window;

    localparam int NI = 5;
    localparam int CW  [NI] = '{64, 16, 8, 8, 8};
    localparam int CNB [NI] = '{2, 4, 3, 3, 3};
    localparam int CM  [NI] = '{0, 0, 2, 1, 0};

    logic clk = 1'b0;
    logic rst = 1'b0, en = 1'b0, in_valid = 1'b0, tick = 1'b0, query = 1'b0;
    logic signed [63:0] in_data = '0;

    logic signed [63:0] o_d0;
    logic signed [15:0] o_d1;
    logic signed [7:0]  o_d2, o_d3, o_d4;
    logic [NI-1:0]      o_v, o_e;
    logic [0:0]         h0;
    logic [1:0]         h1, h2, h3, h4;
    logic [127:0]       b0;
    logic [63:0]        b1;
    logic [23:0]        b2, b3, b4;

    longint act_d [NI];
    int     act_h [NI];
    assign act_d[0] = o_d0;
    assign act_d[1] = longint'(o_d1);
    assign act_d[2] = longint'(o_d2);
    assign act_d[3] = longint'(o_d3);
    assign act_d[4] = longint'(o_d4);
    assign act_h[0] = int'(h0);
    assign act_h[1] = int'(h1);
    assign act_h[2] = int'(h2);
    assign act_h[3] = int'(h3);
    assign act_h[4] = int'(h4);

    always #5 clk = ~clk;

    rtlola_sliding_window #(.DATA_W(64), .NUM_BUCKETS(2), .MODE(0)) u_s64 (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid), .tick(tick),
        .query(query), .out_data(o_d0), .out_valid(o_v[0]), .out_empty(o_e[0]),
        .head_idx(h0), .buckets(b0));
    rtlola_sliding_window #(.DATA_W(16), .NUM_BUCKETS(4), .MODE(0)) u_s16 (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data[15:0]), .in_valid(in_valid), .tick(tick),
        .query(query), .out_data(o_d1), .out_valid(o_v[1]), .out_empty(o_e[1]),
        .head_idx(h1), .buckets(b1));
    rtlola_sliding_window #(.DATA_W(8), .NUM_BUCKETS(3), .MODE(2)) u_m8 (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data[7:0]), .in_valid(in_valid), .tick(tick),
        .query(query), .out_data(o_d2), .out_valid(o_v[2]), .out_empty(o_e[2]),
        .head_idx(h2), .buckets(b2));
    rtlola_sliding_window #(.DATA_W(8), .NUM_BUCKETS(3), .MODE(1)) u_c8 (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data[7:0]), .in_valid(in_valid), .tick(tick),
        .query(query), .out_data(o_d3), .out_valid(o_v[3]), .out_empty(o_e[3]),
        .head_idx(h3), .buckets(b3));
    rtlola_sliding_window #(.DATA_W(8), .NUM_BUCKETS(3), .MODE(0)) u_s8 (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data[7:0]), .in_valid(in_valid), .tick(tick),
        .query(query), .out_data(o_d4), .out_valid(o_v[4]), .out_empty(o_e[4]),
        .head_idx(h4), .buckets(b4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Model: every accepted sample remembered with the tick period it arrived in.
    typedef struct {
        int     p;
        longint v;
    } samp_t;

    samp_t  hist[$];
    int     cur = 0;
    longint nd [NI];
    bit     ne [NI];
    bit     nv [NI];
    longint exp_d [NI];
    bit     exp_e [NI];
    bit     exp_v [NI];
    int     exp_h [NI];
    bit     chk_on = 1'b0;

    function automatic longint sx(input longint x, input int w);
        if (w >= 64) return x;
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic model_agg(input int w, input int nb, input int mode,
                             output longint v, output bit empty);
        int     lo;
        int     pc [4];
        bit     first;
        longint acc;
        longint sat;
        lo    = cur - nb + 1;
        empty = 1'b1;
        first = 1'b1;
        acc   = 0;
        for (int k = 0; k < 4; k++) pc[k] = 0;
        foreach (hist[k]) begin
            if (hist[k].p >= lo) begin
                longint x;
                x     = sx(hist[k].v, w);
                empty = 1'b0;
                if (mode == 0) acc = acc + x;
                else if (mode == 1) pc[hist[k].p - lo]++;
                else if (first || x > acc) acc = x;
                first = 1'b0;
            end
        end
        if (mode == 1) begin
            sat = (w >= 64) ? 64'sh7FFF_FFFF_FFFF_FFFF : ((64'sd1 <<< (w - 1)) - 1);
            for (int k = 0; k < nb; k++) acc = acc + ((longint'(pc[k]) > sat) ? sat : longint'(pc[k]));
        end
        v = empty ? 0 : sx(acc, w);
    endtask

    task automatic step();
        if (rst) begin
            hist.delete();
            cur = 0;
            for (int i = 0; i < NI; i++) begin
                nd[i] = 0; ne[i] = 1'b0; nv[i] = 1'b0;
            end
        end else if (en) begin
            if (tick) begin
                cur++;
                while (hist.size() > 0 && hist[0].p <= cur - 4) hist.delete(0);
            end
            if (in_valid) begin
                samp_t s;
                s.p = cur;
                s.v = in_data;
                hist.push_back(s);
            end
            for (int i = 0; i < NI; i++) begin
                nv[i] = query;
                if (query) model_agg(CW[i], CNB[i], CM[i], nd[i], ne[i]);
            end
        end else begin
            for (int i = 0; i < NI; i++) nv[i] = 1'b0;
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            exp_d[i] = nd[i];
            exp_e[i] = ne[i];
            exp_v[i] = nv[i];
            exp_h[i] = cur % CNB[i];
        end
        chk_on = 1'b1;
        #1;
    endtask

    task automatic cyc(input bit r, input bit e, input bit t, input bit v, input bit q, input longint d);
        rst = r; en = e; tick = t; in_valid = v; query = q; in_data = d;
        step();
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("out_valid[%0d]", i), longint'(o_v[i]), longint'(exp_v[i]));
                chk($sformatf("out_data[%0d]", i), act_d[i], exp_d[i]);
                chk($sformatf("out_empty[%0d]", i), longint'(o_e[i]), longint'(exp_e[i]));
                chk($sformatf("head_idx[%0d]", i), longint'(act_h[i]), longint'(exp_h[i]));
            end
        end
    end

    initial begin
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("rst_head", longint'(act_h[1]), 0);
        chk("rst_valid", longint'(o_v[0]), 0);
        chk("rst_data", act_d[0], 0);
        chk("rst_bkt_sum_zero", longint'(b0 == '0), 1);
        chk("rst_bkt_max_ident", longint'(b2), 64'h80_8080);

        // Sum over two buckets, then eviction
        cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 2);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 3);
        cyc(0, 1, 0, 0, 1, 0);
        chk("sum6_data", act_d[0], 6);
        chk("sum6_valid", longint'(o_v[0]), 1);
        chk("sum6_empty", longint'(o_e[0]), 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("evict_sum3", act_d[0], 3);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("evict_all_data", act_d[0], 0);
        chk("evict_all_empty", longint'(o_e[0]), 1);

        // Simultaneous tick, sample and query; head wrap on four buckets
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 5);
        chk("simul_data", act_d[1], 5);
        chk("simul_head", longint'(act_h[1]), 1);
        repeat (3) cyc(0, 1, 1, 0, 0, 0);
        chk("head_wrap", longint'(act_h[1]), 0);

        // Signed max, then full eviction
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, -7);
        cyc(0, 1, 0, 1, 0, 4);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, -2);
        cyc(0, 1, 0, 0, 1, 0);
        chk("max4", act_d[2], 4);
        repeat (3) cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("max_evicted_data", act_d[2], 0);
        chk("max_evicted_empty", longint'(o_e[2]), 1);

        // 8-bit sum wrap
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 100);
        cyc(0, 1, 0, 1, 0, 100);
        cyc(0, 1, 0, 0, 1, 0);
        chk("sum8_wrap", act_d[4], -56);

        // Count with enable gating
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, longint'(i));
        repeat (3) cyc(0, 0, 0, 1, 0, 9);
        cyc(0, 0, 0, 0, 1, 0);
        chk("en0_no_valid", longint'(o_v[3]), 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("count5", act_d[3], 5);

        // Reset concurrent with a query
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 7);
        cyc(0, 1, 0, 1, 0, 9);
        cyc(1, 1, 0, 0, 1, 0);
        chk("rstq_valid", longint'(o_v[0]), 0);
        chk("rstq_head", longint'(act_h[0]), 0);
        chk("rstq_bkt_zero", longint'(b0 == '0), 1);
        cyc(0, 1, 0, 0, 1, 0);
        chk("rstq_after_data", act_d[0], 0);
        chk("rstq_after_empty", longint'(o_e[0]), 1);

        // Count saturation in one bucket
        cyc(1, 1, 0, 0, 0, 0);
        repeat (130) cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 1, 0);
        chk("count_sat", act_d[3], 127);

        for (int n = 0; n < 3000; n++) begin
            bit     r, e, t, v, q;
            longint d;
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) != 0);
            t = ($urandom_range(0, 4) == 0);
            v = ($urandom_range(0, 1) == 1);
            q = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       d = longint'($urandom_range(0, 20)) - 10;
                1:       d = 127;
                2:       d = -128;
                3:       d = 64'sh7FFF_FFFF_FFFF_FFFF;
                4:       d = 64'sh8000_0000_0000_0000;
                default: d = {$urandom, $urandom};
            endcase
            cyc(r, e, t, v, q, d);
        end
        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
